// File: rtl/ccff_cfg_pkg.sv
// Shared definitions for the configuration-chain loader: FSM states,
// default chain geometry and the word-count helper.
package ccff_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } loader_state_e;

  localparam int DEF_CHAIN_LEN = 16;
  localparam int DEF_WORD_W    = 8;

  // Number of host words needed to cover the whole chain (ceiling division).
  function automatic int words_needed(input int chain_len, input int word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// One-word buffer that hands out its bits MSB-first. Tracks whether a word
// is held and whether the current bit is the word's last one.
module ccff_word_serializer
  import ccff_cfg_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              flush,
  input  logic              load,
  input  logic [WORD_W-1:0] data,
  input  logic              shift,
  output logic              full,
  output logic              head_bit,
  output logic              last_bit
);

  localparam int PTR_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  logic [WORD_W-1:0] word_r;
  logic [PTR_W-1:0]  ptr_r;
  logic              full_r;

  // Buffer/pointer update: flush beats load, load beats a plain shift, so a
  // new word accepted while the last bit leaves replaces it without a bubble.
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      word_r <= {WORD_W{1'b0}};
      ptr_r  <= {PTR_W{1'b0}};
      full_r <= 1'b0;
    end else if (flush) begin
      word_r <= word_r;
      ptr_r  <= {PTR_W{1'b0}};
      full_r <= 1'b0;
    end else if (load) begin
      word_r <= data;
      ptr_r  <= PTR_W'(WORD_W - 1);
      full_r <= 1'b1;
    end else if (shift && full_r) begin
      word_r <= word_r;
      if (ptr_r == {PTR_W{1'b0}}) begin
        ptr_r  <= ptr_r;
        full_r <= 1'b0;
      end else begin
        ptr_r  <= ptr_r - PTR_W'(1);
        full_r <= full_r;
      end
    end else begin
      word_r <= word_r;
      ptr_r  <= ptr_r;
      full_r <= full_r;
    end
  end

  // Flag decode from the buffer registers.
  always_comb begin
    full     = full_r;
    head_bit = word_r[ptr_r];
    last_bit = (ptr_r == {PTR_W{1'b0}});
  end

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Configuration-chain feeder: takes host words over valid/ready, shifts them
// MSB-first into the chain with a clock enable, and in verify mode compares
// the bits coming out of the chain tail against the re-streamed image.
module ccff_bitstream_loader
  import ccff_cfg_pkg::*;
#(
  parameter int CHAIN_LEN = DEF_CHAIN_LEN,
  parameter int WORD_W    = DEF_WORD_W,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              verify,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  err_idx
);

  localparam int WORDS = words_needed(CHAIN_LEN, WORD_W);
  localparam int WA_W  = $clog2(WORDS + 1);

  loader_state_e    state_r;
  loader_state_e    state_nxt_s;
  logic             mode_r;
  logic [CNT_W-1:0] bit_cnt_r;
  logic [WA_W-1:0]  words_acc_r;
  logic             error_r;
  logic [CNT_W-1:0] err_idx_r;

  logic buf_full_s;
  logic buf_bit_s;
  logic buf_last_s;
  logic shift_s;
  logic last_shift_s;
  logic ready_s;
  logic load_s;
  logic flush_s;
  logic mismatch_s;

  // A shift happens whenever the pass is active and a word is buffered; the
  // final chain bit ends the pass and drops whatever is left of the word.
  always_comb begin
    shift_s      = (state_r == ST_SHIFT) && buf_full_s;
    last_shift_s = shift_s && (bit_cnt_r == CNT_W'(CHAIN_LEN - 1));
    ready_s      = (state_r == ST_SHIFT) && (words_acc_r < WA_W'(WORDS)) &&
                   (!buf_full_s || (shift_s && buf_last_s));
    load_s       = cfg_valid && ready_s;
    flush_s      = (state_r != ST_SHIFT) || last_shift_s;
    mismatch_s   = shift_s && mode_r && (ccff_tail != buf_bit_s);
  end

  ccff_word_serializer #(
    .WORD_W (WORD_W)
  ) u_serializer (
    .prog_clk (prog_clk),
    .pReset   (pReset),
    .flush    (flush_s),
    .load     (load_s),
    .data     (cfg_data),
    .shift    (shift_s),
    .full     (buf_full_s),
    .head_bit (buf_bit_s),
    .last_bit (buf_last_s)
  );

  // State register.
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: start only counts in IDLE, DONE lasts one cycle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nxt_s = ST_SHIFT;
        else       state_nxt_s = ST_IDLE;
      end
      ST_SHIFT: begin
        if (last_shift_s) state_nxt_s = ST_DONE;
        else              state_nxt_s = ST_SHIFT;
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Pass bookkeeping: mode capture, bit/word counters and sticky first-mismatch.
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      mode_r      <= 1'b0;
      bit_cnt_r   <= {CNT_W{1'b0}};
      words_acc_r <= {WA_W{1'b0}};
      error_r     <= 1'b0;
      err_idx_r   <= {CNT_W{1'b0}};
    end else if ((state_r == ST_IDLE) && start) begin
      mode_r      <= verify;
      bit_cnt_r   <= {CNT_W{1'b0}};
      words_acc_r <= {WA_W{1'b0}};
      error_r     <= 1'b0;
      err_idx_r   <= {CNT_W{1'b0}};
    end else begin
      if (shift_s) bit_cnt_r <= bit_cnt_r + CNT_W'(1);
      else         bit_cnt_r <= bit_cnt_r;
      if (load_s) words_acc_r <= words_acc_r + WA_W'(1);
      else        words_acc_r <= words_acc_r;
      if (mismatch_s && !error_r) begin
        error_r   <= 1'b1;
        err_idx_r <= bit_cnt_r;
      end else begin
        error_r   <= error_r;
        err_idx_r <= err_idx_r;
      end
    end
  end

  // Output decode; head is forced low while stalled so the chain input is quiet.
  always_comb begin
    cfg_ready     = ready_s;
    ccff_shift_en = shift_s;
    ccff_head     = shift_s ? buf_bit_s : 1'b0;
    busy          = (state_r != ST_IDLE);
    done          = (state_r == ST_DONE);
    error         = error_r;
    err_idx       = err_idx_r;
  end

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader: a 16-flop and a 12-flop instance, each
// with a behavioural chain, checked against stream/image expectations derived
// from the host words.
module tb_ccff_bitstream_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      rst    = 2'b11;
  logic [1:0]      start  = 2'b00;
  logic [1:0]      verify = 2'b00;
  logic [1:0]      valid  = 2'b00;
  logic [1:0][7:0] data   = '0;
  wire  [1:0]      ready, head, sen, busy, done, err, tail;
  wire  [4:0]      eidx0;
  wire  [3:0]      eidx1;

  logic [15:0] chain0 = 16'h0;
  logic [11:0] chain1 = 12'h0;
  logic [15:0] img [2];

  int vectors     = 0;
  int miscompares = 0;

  ccff_bitstream_loader u_dut0 (
    .prog_clk(clk), .pReset(rst[0]), .start(start[0]), .verify(verify[0]),
    .cfg_data(data[0]), .cfg_valid(valid[0]), .cfg_ready(ready[0]),
    .ccff_head(head[0]), .ccff_shift_en(sen[0]), .ccff_tail(tail[0]),
    .busy(busy[0]), .done(done[0]), .error(err[0]), .err_idx(eidx0)
  );

  ccff_bitstream_loader #(.CHAIN_LEN(12)) u_dut1 (
    .prog_clk(clk), .pReset(rst[1]), .start(start[1]), .verify(verify[1]),
    .cfg_data(data[1]), .cfg_valid(valid[1]), .cfg_ready(ready[1]),
    .ccff_head(head[1]), .ccff_shift_en(sen[1]), .ccff_tail(tail[1]),
    .busy(busy[1]), .done(done[1]), .error(err[1]), .err_idx(eidx1)
  );

  // Chain models: flops advance only on clock edges the enable lets through.
  always @(posedge clk) begin
    if (sen[0]) chain0 <= {chain0[14:0], head[0]};
    if (sen[1]) chain1 <= {chain1[10:0], head[1]};
  end
  assign tail = {chain1[11], chain0[15]};

  function automatic int clen(input int d);
    return (d == 0) ? 16 : 12;
  endfunction

  // Expected serial stream: the words MSB-first, cut to the chain length.
  function automatic logic [15:0] stream(input int d, input logic [7:0] w0, input logic [7:0] w1);
    logic [15:0] c;
    c = {w0, w1};
    return c >> (16 - clen(d));
  endfunction

  // Index of the first stream bit where two images differ, -1 if none.
  function automatic int first_diff(input int n, input logic [15:0] a, input logic [15:0] b);
    for (int k = 0; k < n; k++)
      if (a[n-1-k] != b[n-1-k]) return k;
    return -1;
  endfunction

  function automatic logic [31:0] eidx_of(input int d);
    return (d == 0) ? {27'd0, eidx0} : {28'd0, eidx1};
  endfunction

  function automatic logic [31:0] chain_of(input int d);
    return (d == 0) ? {16'd0, chain0} : {20'd0, chain1};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One complete pass on instance d, with an optional host stall counted in
  // cycles where the loader is ready but no word is offered.
  task automatic run_pass(input int d, input bit vm, input logic [7:0] w0,
                          input logic [7:0] w1, input int stall, input string tag);
    int          n;
    logic [15:0] exp;
    logic [31:0] got;
    logic [7:0]  w [2];
    int nshift, gap, done_cnt, done_cyc, last_cyc, widx, late, stall_left, fd;
    bit fin;
    n = clen(d); exp = stream(d, w0, w1); got = 0;
    w[0] = w0; w[1] = w1;
    nshift = 0; gap = 0; done_cnt = 0; done_cyc = -1; last_cyc = -2;
    widx = 0; late = 0; stall_left = 0; fin = 1'b0;
    fd = vm ? first_diff(n, img[d], exp) : -1;
    @(negedge clk); start[d] = 1'b1; verify[d] = vm;
    @(negedge clk); start[d] = 1'b0; verify[d] = 1'b0;
    chk({tag, ".busy_on_start"}, busy[d], 1);
    chk({tag, ".err_cleared"}, err[d], 0);
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      if (sen[d]) begin
        got = (got << 1) | 32'(head[d]); nshift++; last_cyc = cyc;
      end else if (nshift > 0 && nshift < n) gap++;
      if (done[d]) begin done_cnt++; done_cyc = cyc; fin = 1'b1; end
      if (widx == 2 && ready[d]) late++;
      if (stall_left > 0) begin
        valid[d] = 1'b0;
        if (ready[d]) stall_left--;
      end else if (widx < 2 && !fin) begin
        valid[d] = 1'b1; data[d] = w[widx];
        if (ready[d]) begin
          widx++;
          if (widx == 1) stall_left = stall;
        end
      end else valid[d] = 1'b0;
      @(negedge clk);
    end
    valid[d] = 1'b0;
    chk({tag, ".done_pulses"}, done_cnt, 1);
    chk({tag, ".shifts"}, nshift, n);
    chk({tag, ".head_seq"}, got, {16'd0, exp});
    chk({tag, ".stall_gap"}, gap, stall);
    chk({tag, ".done_after_last"}, done_cyc, last_cyc + 1);
    chk({tag, ".words_taken"}, widx, 2);
    chk({tag, ".ready_after_last"}, late, 0);
    chk({tag, ".done_low_idle"}, done[d], 0);
    chk({tag, ".busy_low_idle"}, busy[d], 0);
    chk({tag, ".error"}, err[d], (fd >= 0) ? 1 : 0);
    chk({tag, ".err_idx"}, eidx_of(d), (fd >= 0) ? fd : 0);
    chk({tag, ".chain_image"}, chain_of(d), {16'd0, exp});
    img[d] = exp;
  endtask

  initial begin
    int          cnt, d, k, n;
    logic [7:0]  w0, w1, v0, v1;
    logic [15:0] flip;

    // Reset held two cycles then released.
    repeat (2) @(negedge clk);
    rst = 2'b00;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst.cfg_ready", ready[i], 0);
      chk("rst.head", head[i], 0);
      chk("rst.shift_en", sen[i], 0);
      chk("rst.busy", busy[i], 0);
      chk("rst.done", done[i], 0);
      chk("rst.error", err[i], 0);
      chk("rst.err_idx", eidx_of(i), 0);
    end

    run_pass(0, 1'b0, 8'hA5, 8'h3C, 0, "prog");
    run_pass(0, 1'b1, 8'hA5, 8'h3C, 0, "verify_ok");
    run_pass(0, 1'b1, 8'hA5, 8'h3D, 0, "verify_bad");
    repeat (4) @(negedge clk);
    chk("hold.error", err[0], 1);
    chk("hold.err_idx", eidx_of(0), 15);
    run_pass(0, 1'b0, 8'hA5, 8'h3C, 3, "stall");
    run_pass(1, 1'b0, 8'hA5, 8'hFF, 0, "len12");

    // Reset part-way through a pass on the 12-flop instance.
    @(negedge clk); start[1] = 1'b1;
    @(negedge clk); start[1] = 1'b0;
    cnt = 0;
    for (int cyc = 0; cyc < 50 && cnt < 5; cyc++) begin
      if (sen[1]) cnt++;
      valid[1] = 1'b1; data[1] = 8'h5A;
      @(negedge clk);
    end
    chk("abort.reached_5_shifts", cnt, 5);
    rst[1] = 1'b1;
    @(negedge clk);
    valid[1] = 1'b0;
    chk("abort.shift_en", sen[1], 0);
    chk("abort.busy", busy[1], 0);
    chk("abort.done", done[1], 0);
    chk("abort.cfg_ready", ready[1], 0);
    rst[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort.no_done", done[1], 0);
      chk("abort.idle", busy[1], 0);
    end

    // Random program/verify pairs on both chain lengths.
    for (int i = 0; i < 8; i++) begin
      d  = i % 2;
      n  = clen(d);
      w0 = 8'($urandom);
      w1 = 8'($urandom);
      run_pass(d, 1'b0, w0, w1, $urandom_range(0, 3), "rnd_prog");
      flip = 16'd0;
      if ($urandom_range(0, 1) == 1) begin
        k = $urandom_range(0, n - 1);
        flip[15 - k] = 1'b1;
      end
      v0 = w0 ^ flip[15:8];
      v1 = w1 ^ flip[7:0];
      run_pass(d, 1'b1, v0, v1, $urandom_range(0, 3), "rnd_verify");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ccff_bitstream_loader.md
Name: ccff_bitstream_loader

Overview:
- Upstream feeder for the switch-box/connection-box configuration chain.
- Accepts configuration words from the bitstream host over a valid/ready handshake and serialises them MSB-first onto ccff_head.
- Drives a shift-enable that gates prog_clk to the chain.
- Verify mode re-streams the same image and compares each bit leaving ccff_tail against the bit being shifted in, reporting the first mismatch.

Parameters:
- CHAIN_LEN, 16, number of configuration flops in the chain (8 size-2 muxes x 2 bits).
- WORD_W, 8, host word width in bits.
- CNT_W, $clog2(CHAIN_LEN+1), bit-counter width (derived).

Ports:
- prog_clk  input  1  programming clock; only clock of this block.
- pReset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a pass; ignored unless IDLE.
- verify  input  1  sampled with start: 0 = program pass, 1 = verify pass.
- cfg_data  input  WORD_W  configuration word, MSB shifted first.
- cfg_valid  input  1  cfg_data valid.
- cfg_ready  output  1  loader accepts cfg_data this cycle.
- ccff_head  output  1  serial data into the chain head.
- ccff_shift_en  output  1  chain clock enable; the external clock gate passes prog_clk to the chain only when this is 1.
- ccff_tail  input  1  serial output of the last chain flop.
- busy  output  1  pass in progress.
- done  output  1  one-cycle pulse at end of pass.
- error  output  1  sticky verify mismatch; cleared on next start.
- err_idx  output  CNT_W  bit index of the first mismatch.

Behaviour:
- Reset (pReset=1 at an edge): all outputs are 0 and err_idx=0. The state goes to IDLE and the word buffer and counters clear. Chain contents are then undefined; no done pulse is issued.
- Reset mid-pass aborts immediately. ccff_shift_en is 0 from the next cycle.
- States and transitions:
  - IDLE --start--> SHIFT. mode<=verify, bit_cnt<=0, words_acc<=0. On start, error and err_idx clear.
  - SHIFT --last bit shifted--> DONE.
  - DONE --always--> IDLE, with done=1 for that one cycle.
- busy=1 in SHIFT and DONE.
- Word buffer: holds one word plus bit pointer ptr (WORD_W-1 down to 0). Handshake completes when cfg_valid && cfg_ready.
- cfg_ready = SHIFT && words_acc < ceil(CHAIN_LEN/WORD_W) && (buffer empty || (shifting this cycle && ptr==0)). This lets back-to-back words stream with no bubble.
- Shifting: ccff_shift_en=1 and ccff_head=buf[ptr] in every SHIFT cycle where the buffer holds a word. A word accepted at cycle t is first shifted at t+1.
- Buffer empty (host stall): ccff_shift_en=0 and ccff_head=0. The chain holds its state.
- Each shift increments bit_cnt.
- When bit_cnt reaches CHAIN_LEN-1 on a shift, that shift is the last one. The remaining low bits of the final word are discarded and the next state is DONE.
- Verify compare: on every shift cycle in verify mode, ccff_tail is compared with ccff_head before the edge. The tail carries bit k of the prior pass.
- On the first mismatch: error<=1 and err_idx<=bit_cnt. Later mismatches do not change err_idx.
- Program mode never sets error.
- start asserted while busy is ignored. cfg_valid while not SHIFT is ignored (cfg_ready=0).

Decomposition:
- Shared package ccff_cfg_pkg holds:
  - loader state enum (IDLE, SHIFT, DONE);
  - default CHAIN_LEN and WORD_W;
  - a words_needed(CHAIN_LEN, WORD_W) constant function.
- One sub-module, ccff_word_serializer: one-word buffer, ptr, and the empty/last-bit flags.
- The FSM, counters and verify compare stay in the top module.

Test Plan (bench models a CHAIN_LEN-flop chain clocked by prog_clk && ccff_shift_en; defaults unless stated):
1. pReset held 2 cycles, then released -> cfg_ready, ccff_head, ccff_shift_en, busy, done, error all 0; err_idx=0.
2. Program pass: start with verify=0, then 0xA5 and 0x3C offered back-to-back -> ccff_shift_en high 16 consecutive cycles. Head sequence is 1010_0101_0011_1100. done pulses the cycle after the 16th shift. Chain model holds the image; error=0.
3. Verify pass after test 2 with the same words -> 16 shifts, error=0, done pulse.
4. Verify pass with 0xA5, 0x3D after test 2 -> error=1 and err_idx=15, held until the next start.
5. Stall: cfg_valid low 3 cycles between the two words of test 2 -> ccff_shift_en low exactly 3 cycles and the chain model is unchanged during the gap. The final image equals test 2.
6. CHAIN_LEN=12: words 0xA5, 0xFF -> 12 shifts, head 1010_0101_1111. The low 4 bits of 0xFF are discarded and cfg_ready stays 0 after the second word. Separately, pReset after 5 shifts -> shift_en 0 next cycle, no done, IDLE.
